mips_decode_alu_core: RTL and testbench
=======================================

Name: mips_decode_alu_core

Overview:
- Combined decode and execute core for the 5-stage MIPS32 pipeline: instruction decoder/control unit, 32x32 register file, ALU-control decoder and 32-bit ALU.
- Consumes the IF/ID instruction word and the WB write-back port.
- Produces control micro-signals, register operands, the sign-extended immediate and the ALU result/flags, which feed the ID/EX pipeline registers.

Parameters:
- WRITE_BYPASS, 1: when 1, a read of the register being written this cycle returns dado_escrita (write-through); when 0, returns the stored value.

Ports:
- clock  in  1  system clock; register file writes on rising edge
- reset_n  in  1  asynchronous active-low reset
- instrucao  in  32  instruction word (opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0])
- sinal_escrita  in  1  register-file write enable (from WB)
- reg_escrita  in  5  write address
- dado_escrita  in  32  write data
- out_rs  out  32  read data at rs
- out_rt  out  32  read data at rt
- se_imediato  out  32  imm sign-extended
- c_ALUOp  out  2  00 add, 01 sub, 10 R-type (use funct)
- c_memoria  out  2  00 none, 01 read, 10 write
- c_desvio  out  3  000 none, 001 beq, 010 bne, 100 jump
- c_fonte_ula  out  1  1 = ALU B operand is se_imediato
- c_memtoreg  out  1  1 = WB from memory
- c_escrever_reg  out  1  register write enable for this instruction
- c_reg_destino  out  1  1 = destination rd, 0 = rt
- operacao  out  3  ALU operation code
- resultado_ula  out  32  ALU result
- zero  out  1  resultado_ula == 0
- overflow  out  1  signed overflow

Behaviour:
- Register file:
  - 32 x 32-bit, combinational reads.
  - Register 0 always reads 0; writes to it are ignored.
  - On a rising clock edge with sinal_escrita=1 and reset_n=1, the register at reg_escrita takes dado_escrita.
  - reset_n low asynchronously clears all registers to 0 and blocks writes; out_rs/out_rt read 0 while reset is held.
  - With WRITE_BYPASS=1 and sinal_escrita=1, a read whose address equals reg_escrita (nonzero) returns dado_escrita in the same cycle.
- Control decode: fields are {ALUOp, memoria, desvio, fonte_ula, memtoreg, escrever_reg, reg_destino}.
  - 000000 R-type: {10, 00, 000, 0, 0, 1, 1}
  - 100011 lw: {00, 01, 000, 1, 1, 1, 0}
  - 101011 sw: {00, 10, 000, 1, 0, 0, 0}
  - 000100 beq: {01, 00, 001, 0, 0, 0, 0}
  - 000101 bne: {01, 00, 010, 0, 0, 0, 0}
  - 001000 addi: {00, 00, 000, 1, 0, 1, 0}
  - 000010 j: {00, 00, 100, 0, 0, 0, 0}
  - Any other opcode: all outputs 0 (NOP).
- ALU control:
  - ALUOp 00 -> 010 (add); ALUOp 01 -> 110 (sub); ALUOp 11 -> 101.
  - ALUOp 10 decodes funct: 100000 -> 010 add, 100010 -> 110 sub, 100100 -> 000 and, 100101 -> 001 or, 101010 -> 111 slt.
  - Any other funct -> 101 (invalid).
- ALU operands: A = out_rs; B = c_fonte_ula ? se_imediato : out_rt.
- ALU operations, all purely combinational, zero added latency:
  - 000 A&B; 001 A|B; 010 A+B; 110 A-B, all mod 2^32.
  - 111: result is 1 if signed A < signed B, else 0.
  - 101 and any unlisted code: result 0.
- Flags:
  - overflow is set only for add/sub: operand signs match (add) or differ (sub) and the result sign differs from A. It is 0 for all other operations.
  - zero always equals (resultado_ula == 0), including invalid operations.
- All outputs except register contents follow the inputs with no latency; nothing besides the register array is stored.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined:
  - R-type funct 000000 -> operacao 011, result = B << shamt.
  - R-type funct 000010 -> operacao 100, result = B >> shamt (logical).
  - overflow = 0 for both.
  - The all-zero instruction is then sll $0,$0,0, a harmless NOP.
- Undefined: both functs decode to 101, and operacao 011/100 produce result 0.

Test Plan:
- Reset, then read all 32 registers -> all 0. Write reg 0 with 0xFFFFFFFF -> still reads 0.
- Write reg 5 = 0x0000000A and reg 6 = 0x00000003, then add $7,$5,$6 (0x00A63820) -> out_rs=0xA, out_rt=3, operacao=010, resultado_ula=0xD, control {10,00,000,0,0,1,1}.
- Same-cycle write of reg 5 = 0x12345678 while decoding an instruction with rs=5 -> with WRITE_BYPASS=1, out_rs=0x12345678 before the clock edge.
- addi with imm 0xFFFF and rs=0x7FFFFFFF -> se_imediato=0xFFFFFFFF, result 0x7FFFFFFE, overflow=0. sub with A=0x80000000, B=1 -> 0x7FFFFFFF, overflow=1.
- beq with equal operands -> c_desvio=001, operacao=110, zero=1. slt with A=0xFFFFFFFF, B=1 -> result 1.
- Unknown opcode 111111 -> all control outputs 0. Assert reset_n mid-write -> registers 0 and write suppressed.

Source files
------------

// File: rtl/mips_decode_alu_core.sv
// MIPS32 decode/execute core: control decode, 32x32 regfile, ALU control, ALU.
// Optional ALU_SHIFT_EN macro adds sll/srl (operacao 011/100).
module mips_decode_alu_core #(
  parameter int unsigned WRITE_BYPASS = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instrucao,
  input  logic        sinal_escrita,
  input  logic [4:0]  reg_escrita,
  input  logic [31:0] dado_escrita,
  output logic [31:0] out_rs,
  output logic [31:0] out_rt,
  output logic [31:0] se_imediato,
  output logic [1:0]  c_ALUOp,
  output logic [1:0]  c_memoria,
  output logic [2:0]  c_desvio,
  output logic        c_fonte_ula,
  output logic        c_memtoreg,
  output logic        c_escrever_reg,
  output logic        c_reg_destino,
  output logic [2:0]  operacao,
  output logic [31:0] resultado_ula,
  output logic        zero,
  output logic        overflow
);

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] mem;
    logic [2:0] br;
    logic       src_imm;
    logic       mem2reg;
    logic       wr;
    logic       dst_rd;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
`ifdef ALU_SHIFT_EN
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
`endif

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_INV = 3'b101;
`ifdef ALU_SHIFT_EN
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
`endif

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = instrucao[31:26];
  assign rs     = instrucao[25:21];
  assign rt     = instrucao[20:16];
  assign imm    = instrucao[15:0];
  assign funct  = instrucao[5:0];

  logic [31:0] regs_q [32];
  logic        wr_en;

  assign wr_en = sinal_escrita && (reg_escrita != 5'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[reg_escrita] <= dado_escrita;
    end
  end

  // Bypass and $0 forcing are gated by reset so reads stay 0 while held.
  always_comb begin
    out_rs = regs_q[rs];
    if (WRITE_BYPASS != 0 && wr_en && rs == reg_escrita)
      out_rs = dado_escrita;
    if (rs == 5'd0 || !reset_n)
      out_rs = '0;
  end

  always_comb begin
    out_rt = regs_q[rt];
    if (WRITE_BYPASS != 0 && wr_en && rt == reg_escrita)
      out_rt = dado_escrita;
    if (rt == 5'd0 || !reset_n)
      out_rt = '0;
  end

  assign se_imediato = {{16{imm[15]}}, imm};

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_RTYPE): ctrl = '{2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
      (opcode == OP_LW):    ctrl = '{2'b00, 2'b01, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
      (opcode == OP_SW):    ctrl = '{2'b00, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
      (opcode == OP_BEQ):   ctrl = '{2'b01, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
      (opcode == OP_BNE):   ctrl = '{2'b01, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
      (opcode == OP_ADDI):  ctrl = '{2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
      (opcode == OP_J):     ctrl = '{2'b00, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0};
      default:              ctrl = '0;
    endcase
  end

  assign c_ALUOp        = ctrl.alu_op;
  assign c_memoria      = ctrl.mem;
  assign c_desvio       = ctrl.br;
  assign c_fonte_ula    = ctrl.src_imm;
  assign c_memtoreg     = ctrl.mem2reg;
  assign c_escrever_reg = ctrl.wr;
  assign c_reg_destino  = ctrl.dst_rd;

  logic [2:0] fn_op;

  always_comb begin
    fn_op = ALU_INV;
    unique case (1'b1)
      (funct == FN_ADD): fn_op = ALU_ADD;
      (funct == FN_SUB): fn_op = ALU_SUB;
      (funct == FN_AND): fn_op = ALU_AND;
      (funct == FN_OR):  fn_op = ALU_OR;
      (funct == FN_SLT): fn_op = ALU_SLT;
`ifdef ALU_SHIFT_EN
      (funct == FN_SLL): fn_op = ALU_SLL;
      (funct == FN_SRL): fn_op = ALU_SRL;
`endif
      default:           fn_op = ALU_INV;
    endcase
  end

  always_comb begin
    operacao = ALU_INV;
    unique case (ctrl.alu_op)
      2'b00:   operacao = ALU_ADD;
      2'b01:   operacao = ALU_SUB;
      2'b10:   operacao = fn_op;
      default: operacao = ALU_INV;
    endcase
  end

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf_add;
  logic        ovf_sub;

  assign op_a = out_rs;
  assign op_b = ctrl.src_imm ? se_imediato : out_rt;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  assign ovf_add = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
  assign ovf_sub = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);

  always_comb begin
    resultado_ula = '0;
    overflow      = 1'b0;
    case (operacao)
      ALU_AND: resultado_ula = op_a & op_b;
      ALU_OR:  resultado_ula = op_a | op_b;
      ALU_ADD: begin
        resultado_ula = sum;
        overflow      = ovf_add;
      end
      ALU_SUB: begin
        resultado_ula = diff;
        overflow      = ovf_sub;
      end
      ALU_SLT: resultado_ula = {31'd0, $signed(op_a) < $signed(op_b)};
`ifdef ALU_SHIFT_EN
      ALU_SLL: resultado_ula = op_b << instrucao[10:6];
      ALU_SRL: resultado_ula = op_b >> instrucao[10:6];
`endif
      default: resultado_ula = '0;
    endcase
  end

  assign zero = (resultado_ula == 32'd0);

endmodule

// File: tb/tb_mips_decode_alu_core.sv
// Scoreboard bench for mips_decode_alu_core: driver queues expectations,
// monitor pops and compares on each falling clock edge.
module tb_mips_decode_alu_core;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instrucao = '0;
  logic        sinal_escrita = 1'b0;
  logic [4:0]  reg_escrita = '0;
  logic [31:0] dado_escrita = '0;
  logic [31:0] out_rs, out_rt, se_imediato, resultado_ula;
  logic [1:0]  c_ALUOp, c_memoria;
  logic [2:0]  c_desvio, operacao;
  logic        c_fonte_ula, c_memtoreg, c_escrever_reg, c_reg_destino;
  logic        zero, overflow;

  mips_decode_alu_core dut (
    .clock(clock), .reset_n(reset_n), .instrucao(instrucao),
    .sinal_escrita(sinal_escrita), .reg_escrita(reg_escrita),
    .dado_escrita(dado_escrita), .out_rs(out_rs), .out_rt(out_rt),
    .se_imediato(se_imediato), .c_ALUOp(c_ALUOp), .c_memoria(c_memoria),
    .c_desvio(c_desvio), .c_fonte_ula(c_fonte_ula), .c_memtoreg(c_memtoreg),
    .c_escrever_reg(c_escrever_reg), .c_reg_destino(c_reg_destino),
    .operacao(operacao), .resultado_ula(resultado_ula), .zero(zero),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int          id;
    logic [6:0]  m;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [10:0] ctrl;
    logic [2:0]  op;
    logic [31:0] res;
    logic        z;
    logic        v;
  } exp_t;

  localparam logic [6:0] M_RS = 7'h01, M_RT = 7'h02, M_IMM = 7'h04;
  localparam logic [6:0] M_CT = 7'h08, M_OP = 7'h10, M_RES = 7'h20;
  localparam logic [6:0] M_FL = 7'h40, M_ALL = 7'h7f;

  localparam logic [10:0] C_R    = 11'b10_00_000_0011;
  localparam logic [10:0] C_LW   = 11'b00_01_000_1110;
  localparam logic [10:0] C_SW   = 11'b00_10_000_1000;
  localparam logic [10:0] C_BEQ  = 11'b01_00_001_0000;
  localparam logic [10:0] C_BNE  = 11'b01_00_010_0000;
  localparam logic [10:0] C_ADDI = 11'b00_00_000_1010;
  localparam logic [10:0] C_J    = 11'b00_00_100_0000;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int vid = 0;

  function automatic exp_t mk(
    input logic [6:0] m, input logic [31:0] rs, input logic [31:0] rt,
    input logic [31:0] imm, input logic [10:0] ctrl, input logic [2:0] op,
    input logic [31:0] res, input logic z, input logic v);
    exp_t e;
    e = '{id: 0, m: m, rs: rs, rt: rt, imm: imm, ctrl: ctrl, op: op,
          res: res, z: z, v: v};
    return e;
  endfunction

  task automatic cmp(input int id, input string nm,
                     input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL vec%0d %s: got %h want %h", id, nm, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.m[0]) cmp(e.id, "out_rs", out_rs, e.rs);
        if (e.m[1]) cmp(e.id, "out_rt", out_rt, e.rt);
        if (e.m[2]) cmp(e.id, "se_imediato", se_imediato, e.imm);
        if (e.m[3]) cmp(e.id, "ctrl", 32'({c_ALUOp, c_memoria, c_desvio,
            c_fonte_ula, c_memtoreg, c_escrever_reg, c_reg_destino}),
            32'(e.ctrl));
        if (e.m[4]) cmp(e.id, "operacao", 32'(operacao), 32'(e.op));
        if (e.m[5]) cmp(e.id, "resultado", resultado_ula, e.res);
        if (e.m[6]) cmp(e.id, "zero_ovf", 32'({zero, overflow}),
            32'({e.z, e.v}));
      end
    end
  end

  task automatic vec(input logic rst, input logic [31:0] ins,
                     input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input exp_t e);
    @(posedge clock);
    #1;
    reset_n = rst;
    instrucao = ins;
    sinal_escrita = we;
    reg_escrita = wa;
    dado_escrita = wd;
    e.id = vid;
    vid++;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    vec(1'b1, 32'h0, 1'b1, wa, wd, mk('0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin : driver
    logic [4:0] a, b;
    int n;
    // Reset held: all reads zero, even with a write to the read address.
    for (int i = 0; i < 16; i++) begin
      a = 5'(i);
      b = 5'(i + 16);
      vec(1'b0, {6'b0, a, b, 16'h0}, 1'b1, b, 32'hFFFF_FFFF,
          mk(M_RS | M_RT, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    vec(1, {6'b0, 5'd16, 5'd31, 16'h0}, 0, 0, 0,
        mk(M_RS | M_RT, 0, 0, 0, 0, 0, 0, 0, 0));
    vec(1, 32'h0, 1, 5'd0, 32'hFFFF_FFFF,
        mk(M_RS | M_RT, 0, 0, 0, 0, 0, 0, 0, 0));
    vec(1, 32'h0, 0, 0, 0, mk(M_RS | M_RT, 0, 0, 0, 0, 0, 0, 0, 0));
    vec(1, 32'h00A0_0000, 1, 5'd5, 32'hA, mk(M_RS, 32'hA, 0, 0, 0, 0, 0, 0, 0));
    vec(1, 32'h00A6_3820, 1, 5'd6, 32'h3,
        mk(M_ALL, 32'hA, 32'h3, 32'h3820, C_R, 3'b010, 32'hD, 0, 0));
    vec(1, 32'h00A6_3820, 0, 0, 0,
        mk(M_ALL, 32'hA, 32'h3, 32'h3820, C_R, 3'b010, 32'hD, 0, 0));
    vec(1, 32'h00A6_3820, 1, 5'd5, 32'h1234_5678,
        mk(M_ALL, 32'h1234_5678, 3, 32'h3820, C_R, 3'b010, 32'h1234_567B, 0, 0));
    vec(1, 32'h00A6_3820, 0, 0, 0,
        mk(M_ALL, 32'h1234_5678, 3, 32'h3820, C_R, 3'b010, 32'h1234_567B, 0, 0));
    wr(5'd8, 32'h7FFF_FFFF);
    vec(1, 32'h2109_FFFF, 0, 0, 0,
        mk(M_ALL, 32'h7FFF_FFFF, 0, 32'hFFFF_FFFF, C_ADDI, 3'b010,
           32'h7FFF_FFFE, 0, 0));
    vec(1, 32'h0108_6020, 0, 0, 0,
        mk(M_ALL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h6020, C_R, 3'b010,
           32'hFFFF_FFFE, 0, 1));
    wr(5'd10, 32'h8000_0000);
    wr(5'd11, 32'h1);
    vec(1, 32'h014B_6022, 0, 0, 0,
        mk(M_ALL, 32'h8000_0000, 1, 32'h6022, C_R, 3'b110, 32'h7FFF_FFFF, 0, 1));
    vec(1, 32'h00A5_6022, 0, 0, 0,
        mk(M_ALL, 32'h1234_5678, 32'h1234_5678, 32'h6022, C_R, 3'b110, 0, 1, 0));
    vec(1, 32'h10A5_0004, 0, 0, 0,
        mk(M_ALL, 32'h1234_5678, 32'h1234_5678, 4, C_BEQ, 3'b110, 0, 1, 0));
    vec(1, 32'h14A5_0004, 0, 0, 0,
        mk(M_CT | M_OP | M_RES | M_FL, 0, 0, 0, C_BNE, 3'b110, 0, 1, 0));
    wr(5'd13, 32'hFFFF_FFFF);
    vec(1, 32'h01AB_702A, 0, 0, 0,
        mk(M_ALL, 32'hFFFF_FFFF, 1, 32'h702A, C_R, 3'b111, 1, 0, 0));
    vec(1, 32'h016D_702A, 0, 0, 0,
        mk(M_ALL, 1, 32'hFFFF_FFFF, 32'h702A, C_R, 3'b111, 0, 1, 0));
    vec(1, 32'h00A6_7024, 0, 0, 0,
        mk(M_CT | M_OP | M_RES | M_FL, 0, 0, 0, C_R, 3'b000, 0, 1, 0));
    vec(1, 32'h00A6_7025, 0, 0, 0,
        mk(M_CT | M_OP | M_RES | M_FL, 0, 0, 0, C_R, 3'b001, 32'h1234_567B, 0, 0));
    vec(1, 32'h8CA9_8000, 0, 0, 0,
        mk(M_ALL, 32'h1234_5678, 0, 32'hFFFF_8000, C_LW, 3'b010,
           32'h1233_D678, 0, 0));
    vec(1, 32'hACA9_8000, 0, 0, 0,
        mk(M_CT | M_OP | M_RES | M_FL, 0, 0, 0, C_SW, 3'b010, 32'h1233_D678, 0, 0));
    vec(1, 32'h0800_0010, 0, 0, 0,
        mk(M_IMM | M_CT | M_OP | M_RES | M_FL, 0, 0, 32'h10, C_J, 3'b010, 0, 1, 0));
    vec(1, 32'hFCA6_0000, 0, 0, 0,
        mk(M_CT | M_OP | M_RES | M_FL, 0, 0, 0, 11'd0, 3'b010,
           32'h1234_567B, 0, 0));
    vec(1, 32'h00A6_7007, 0, 0, 0,
        mk(M_CT | M_OP | M_RES | M_FL, 0, 0, 0, C_R, 3'b101, 0, 1, 0));
`ifdef ALU_SHIFT_EN
    vec(1, 32'h0006_7100, 0, 0, 0,
        mk(M_ALL, 0, 3, 32'h7100, C_R, 3'b011, 32'h30, 0, 0));
    vec(1, 32'h0006_7042, 0, 0, 0,
        mk(M_ALL, 0, 3, 32'h7042, C_R, 3'b100, 32'h1, 0, 0));
    vec(1, 32'h0, 0, 0, 0, mk(M_ALL, 0, 0, 0, C_R, 3'b011, 0, 1, 0));
`else
    vec(1, 32'h0006_7100, 0, 0, 0,
        mk(M_ALL, 0, 3, 32'h7100, C_R, 3'b101, 0, 1, 0));
    vec(1, 32'h0006_7042, 0, 0, 0,
        mk(M_ALL, 0, 3, 32'h7042, C_R, 3'b101, 0, 1, 0));
    vec(1, 32'h0, 0, 0, 0, mk(M_ALL, 0, 0, 0, C_R, 3'b101, 0, 1, 0));
`endif
    // Reset asserted together with a write: write dropped, regs cleared.
    vec(0, 32'h00A6_3820, 1, 5'd5, 32'hDEAD_BEEF,
        mk(M_RS | M_RT, 0, 0, 0, 0, 0, 0, 0, 0));
    vec(1, 32'h00A6_3820, 0, 0, 0,
        mk(M_RS | M_RT | M_RES | M_FL, 0, 0, 0, 0, 0, 0, 1, 0));
    vec(1, {6'b0, 5'd8, 5'd13, 16'h0}, 0, 0, 0,
        mk(M_RS | M_RT, 0, 0, 0, 0, 0, 0, 0, 0));
    n = 0;
    while (sb.size() > 0 && n < 8) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
